operand_entry_ctrl: RTL and testbench

//  Sequences keypad operand entry for the Booth multiplier.
//  - Collects up to 4 decimal digits per operand into a BCD entry register.
//  - Converts each entry to binary through an internal bcd_bin instance.
//  - Captures operand A, then operand B, and offers the pair downstream on a valid/ready handshake.
//  - Exposes the live BCD entry for the 7-segment display path.

---
 rtl/operand_entry_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_operand_entry_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry_ctrl.sv
// ---------------------------------------------------------------------------
// operand_entry_ctrl
//   Sequences keypad operand entry for the Booth multiplier. Up to four
//   decimal digits are collected into a BCD entry register. On Enter the
//   entry is converted to binary and captured as operand A, then operand B.
//   The captured pair is then offered downstream on a valid/ready handshake.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   key_valid  in   1   one-cycle strobe qualifying key_code
//   key_code   in   4   0-9 digit, A enter, B clear, C backspace, D-F illegal
//   op_a       out  14  captured binary operand A
//   op_b       out  14  captured binary operand B
//   op_valid   out  1   operand pair valid
//   op_ready   in   1   downstream accepts the pair
//   disp_bcd   out  16  live entry {d3,d2,d1,d0}, d0 = most recent digit
//   disp_cnt   out  3   number of digits in the live entry, 0..4
//   state      out  2   00 S_A, 01 S_B, 10 S_OUT
//   err        out  1   one-cycle pulse, previous key rejected
// ---------------------------------------------------------------------------

// Four-digit BCD to binary converter (pure combinational).
module bcd_bin (
    input  logic [15:0] bcd_i,
    output logic [13:0] bin_o
);
    logic [13:0] d3_s;
    logic [13:0] d2_s;
    logic [13:0] d1_s;
    logic [13:0] d0_s;

    // Weight each digit by its decimal place and sum.
    always_comb begin
        d3_s  = {10'd0, bcd_i[15:12]};
        d2_s  = {10'd0, bcd_i[11:8]};
        d1_s  = {10'd0, bcd_i[7:4]};
        d0_s  = {10'd0, bcd_i[3:0]};
        bin_o = (d3_s * 14'd1000) + (d2_s * 14'd100) + (d1_s * 14'd10) + d0_s;
    end
endmodule

module operand_entry_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [13:0] op_a,
    output logic [13:0] op_b,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [15:0] disp_bcd,
    output logic [2:0]  disp_cnt,
    output logic [1:0]  state,
    output logic        err
);
    localparam int         BIN_W = 14;
    localparam logic [2:0] NDIG  = 3'd4;

    localparam logic [1:0] S_A   = 2'b00;
    localparam logic [1:0] S_B   = 2'b01;
    localparam logic [1:0] S_OUT = 2'b10;

    localparam logic [3:0] K_ENTER = 4'hA;
    localparam logic [3:0] K_CLEAR = 4'hB;
    localparam logic [3:0] K_BKSP  = 4'hC;

    logic [1:0]       state_q,    state_d;
    logic [BIN_W-1:0] op_a_q,     op_a_d;
    logic [BIN_W-1:0] op_b_q,     op_b_d;
    logic             op_valid_q, op_valid_d;
    logic [15:0]      disp_bcd_q, disp_bcd_d;
    logic [2:0]       disp_cnt_q, disp_cnt_d;
    logic             err_q,      err_d;

    logic [BIN_W-1:0] entry_bin_s;

    bcd_bin u_bcd_bin (
        .bcd_i (disp_bcd_q),
        .bin_o (entry_bin_s)
    );

    // Next-state logic for the entry sequencer and the output handshake.
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_valid_d = op_valid_q;
        disp_bcd_d = disp_bcd_q;
        disp_cnt_d = disp_cnt_q;
        err_d      = 1'b0;

        case (state_q)
            S_A, S_B: begin
                if (key_valid) begin
                    if (key_code <= 4'd9) begin
                        // A full entry refuses further digits rather than scrolling.
                        if (disp_cnt_q < NDIG) begin
                            disp_bcd_d = {disp_bcd_q[11:0], key_code};
                            disp_cnt_d = disp_cnt_q + 3'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        case (key_code)
                            K_CLEAR: begin
                                disp_bcd_d = 16'h0000;
                                disp_cnt_d = 3'd0;
                            end
                            K_BKSP: begin
                                if (disp_cnt_q != 3'd0) begin
                                    disp_bcd_d = {4'h0, disp_bcd_q[15:4]};
                                    disp_cnt_d = disp_cnt_q - 3'd1;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            K_ENTER: begin
                                if (disp_cnt_q == 3'd0) begin
                                    err_d = 1'b1;
                                end else begin
                                    disp_bcd_d = 16'h0000;
                                    disp_cnt_d = 3'd0;
                                    if (state_q == S_A) begin
                                        op_a_d  = entry_bin_s;
                                        state_d = S_B;
                                    end else begin
                                        op_b_d     = entry_bin_s;
                                        state_d    = S_OUT;
                                        op_valid_d = 1'b1;
                                    end
                                end
                            end
                            default: begin
                                err_d = 1'b1;
                            end
                        endcase
                    end
                end else begin
                    err_d = 1'b0;
                end
            end
            S_OUT: begin
                // Keypad is locked while the pair is pending, handshake cycle included.
                err_d = key_valid;
                if (op_valid_q && op_ready) begin
                    state_d    = S_A;
                    op_valid_d = 1'b0;
                end else begin
                    op_valid_d = 1'b1;
                end
            end
            default: begin
                // Unused encoding: recover to a clean idle entry state.
                state_d    = S_A;
                op_valid_d = 1'b0;
                disp_bcd_d = 16'h0000;
                disp_cnt_d = 3'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_A;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            disp_bcd_q <= 16'h0000;
            disp_cnt_q <= 3'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
            disp_bcd_q <= disp_bcd_d;
            disp_cnt_q <= disp_cnt_d;
            err_q      <= err_d;
        end
    end

    assign state    = state_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_valid = op_valid_q;
    assign disp_bcd = disp_bcd_q;
    assign disp_cnt = disp_cnt_q;
    assign err      = err_q;
endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Self-checking bench for operand_entry_ctrl: directed scenarios with literal
// expectations, then randomized keys checked against a digit-list model.
module tb_operand_entry_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        op_ready = 1'b0;
    logic [13:0] op_a;
    logic [13:0] op_b;
    logic        op_valid;
    logic [15:0] disp_bcd;
    logic [2:0]  disp_cnt;
    logic [1:0]  state;
    logic        err;

    int total = 0;
    int bad   = 0;

    // Model: phase 0 = entering A, 1 = entering B, 2 = pair offered.
    int m_phase;
    int m_opa;
    int m_opb;
    int m_err;
    int m_digs[$];

    operand_entry_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .disp_bcd  (disp_bcd),
        .disp_cnt  (disp_cnt),
        .state     (state),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic int m_disp();
        int d = 0;
        foreach (m_digs[i]) d = d * 16 + m_digs[i];
        return d;
    endfunction

    function automatic int m_val();
        int v = 0;
        foreach (m_digs[i]) v = v * 10 + m_digs[i];
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("op_a", int'(op_a), m_opa);
        chk("op_b", int'(op_b), m_opb);
        chk("op_valid", int'(op_valid), (m_phase == 2) ? 1 : 0);
        chk("state", int'(state), m_phase);
        chk("disp_bcd", int'(disp_bcd), m_disp());
        chk("disp_cnt", int'(disp_cnt), m_digs.size());
        chk("err", int'(err), m_err);
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_opa   = 0;
        m_opb   = 0;
        m_err   = 0;
        m_digs.delete();
    endtask

    task automatic model_step(input bit kv, input int kc, input bit rdy);
        m_err = 0;
        if (m_phase == 2) begin
            if (kv) m_err = 1;
            if (rdy) m_phase = 0;
        end else if (kv) begin
            if (kc <= 9) begin
                if (m_digs.size() < 4) m_digs.push_back(kc);
                else m_err = 1;
            end else if (kc == 11) begin
                m_digs.delete();
            end else if (kc == 12) begin
                if (m_digs.size() > 0) void'(m_digs.pop_back());
                else m_err = 1;
            end else if (kc == 10) begin
                if (m_digs.size() == 0) begin
                    m_err = 1;
                end else begin
                    if (m_phase == 0) begin
                        m_opa   = m_val();
                        m_phase = 1;
                    end else begin
                        m_opb   = m_val();
                        m_phase = 2;
                    end
                    m_digs.delete();
                end
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic cycle(input bit kv, input logic [3:0] kc, input bit rdy);
        @(negedge clk);
        key_valid = kv;
        key_code  = kc;
        op_ready  = rdy;
        model_step(kv, int'(kc), rdy);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [3:0] seq1 [8];
        logic [3:0] seq2 [7];
        int r;
        bit kv;
        bit rdy;
        logic [3:0] kc;

        seq1 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'hA, 4'd5, 4'd6, 4'hA};
        seq2 = '{4'd9, 4'd9, 4'd9, 4'd9, 4'hA, 4'd0, 4'hA};

        // Reset state
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check_outputs();
        chk("rst_state_lit", int'(state), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: 1234 / 56 with ready high
        foreach (seq1[i]) cycle(1'b1, seq1[i], 1'b1);
        chk("t1_op_a_lit", int'(op_a), 1234);
        chk("t1_op_b_lit", int'(op_b), 56);
        chk("t1_valid_lit", int'(op_valid), 1);
        cycle(1'b0, 4'h0, 1'b1);
        chk("t1_valid_drop_lit", int'(op_valid), 0);
        chk("t1_state_lit", int'(state), 0);

        // 2: max value and zero
        foreach (seq2[i]) cycle(1'b1, seq2[i], 1'b0);
        chk("t2_op_a_lit", int'(op_a), 'h270F);
        chk("t2_op_b_lit", int'(op_b), 0);
        chk("t2_valid_lit", int'(op_valid), 1);
        cycle(1'b0, 4'h0, 1'b1);

        // 3: fifth digit rejected, backspace then digit
        cycle(1'b1, 4'd1, 1'b0);
        cycle(1'b1, 4'd2, 1'b0);
        cycle(1'b1, 4'd3, 1'b0);
        cycle(1'b1, 4'd4, 1'b0);
        cycle(1'b1, 4'd7, 1'b0);
        chk("t3_err_lit", int'(err), 1);
        chk("t3_disp_lit", int'(disp_bcd), 'h1234);
        cycle(1'b1, 4'hC, 1'b0);
        cycle(1'b1, 4'd8, 1'b0);
        chk("t3_disp2_lit", int'(disp_bcd), 'h1238);
        chk("t3_err_clear_lit", int'(err), 0);
        cycle(1'b1, 4'hB, 1'b0);
        chk("t3_clear_cnt_lit", int'(disp_cnt), 0);

        // 4: enter/backspace on empty entry, illegal code
        cycle(1'b1, 4'hA, 1'b0);
        chk("t4_enter_err_lit", int'(err), 1);
        cycle(1'b1, 4'hC, 1'b0);
        chk("t4_bksp_err_lit", int'(err), 1);
        cycle(1'b1, 4'hE, 1'b0);
        chk("t4_illegal_err_lit", int'(err), 1);
        chk("t4_state_lit", int'(state), 0);
        cycle(1'b1, 4'hB, 1'b0);
        chk("t4_clear_noerr_lit", int'(err), 0);

        // 5: pair held under backpressure, key rejected meanwhile
        cycle(1'b1, 4'd1, 1'b0);
        cycle(1'b1, 4'd2, 1'b0);
        cycle(1'b1, 4'hA, 1'b0);
        cycle(1'b1, 4'd3, 1'b0);
        cycle(1'b1, 4'd4, 1'b0);
        cycle(1'b1, 4'hA, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle((i == 2), 4'd7, 1'b0);
            if (i == 2) chk("t5_key_err_lit", int'(err), 1);
        end
        chk("t5_op_a_lit", int'(op_a), 12);
        chk("t5_op_b_lit", int'(op_b), 34);
        chk("t5_valid_lit", int'(op_valid), 1);
        cycle(1'b0, 4'h0, 1'b1);
        chk("t5_xfer_lit", int'(op_valid), 0);
        cycle(1'b0, 4'h0, 1'b1);

        // 6: async reset while in S_B with 0042 entered
        cycle(1'b1, 4'd5, 1'b0);
        cycle(1'b1, 4'hA, 1'b0);
        cycle(1'b1, 4'd4, 1'b0);
        cycle(1'b1, 4'd2, 1'b0);
        chk("t6_state_lit", int'(state), 1);
        chk("t6_disp_lit", int'(disp_bcd), 'h0042);
        key_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("t6_op_a_rst_lit", int'(op_a), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            kv  = ($urandom_range(0, 99) < 60);
            rdy = ($urandom_range(0, 99) < 35);
            r   = $urandom_range(0, 99);
            if (r < 55)      kc = 4'($urandom_range(0, 9));
            else if (r < 72) kc = 4'hA;
            else if (r < 78) kc = 4'hB;
            else if (r < 90) kc = 4'hC;
            else             kc = 4'($urandom_range(13, 15));
            cycle(kv, kc, rdy);
        end

        key_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
